// File: rtl/mips_trace_uart_tx.sv
// Trace transmitter: buffers retired MIPS instruction words in a FIFO and sends each one
// as a 6-byte 8N1 UART frame (A5, instr MSB..LSB, seq) to an off-chip debug host.
module mips_trace_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 16,
  parameter int FILTER_NOP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trace_valid,
  input  logic [31:0]              trace_instr,
  input  logic                     enable,
  input  logic                     clear_overflow,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [2:0]      byte_idx_q, byte_idx_d;
  logic [39:0]     frame_q, frame_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      seq_q, seq_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic [39:0]     mem [DEPTH];

  logic            is_nop;
  logic            cap;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic            bit_last;
  logic [7:0]      cur_byte;

  // A full FIFO still accepts a capture when the FSM frees a slot in the same cycle.
  always_comb begin
    is_nop   = (FILTER_NOP != 0) && (trace_instr == 32'h0);
    cap      = trace_valid & enable & ~is_nop;
    full     = (count_q == FULL_LVL);
    pop      = (state_q == IDLE) && (count_q != '0);
    push     = cap & (~full | pop);
    drop     = cap & full & ~pop;
    bit_last = (bit_cnt_q == BIT_LAST);
  end

  always_comb begin
    case (byte_idx_q)
      3'd0:    cur_byte = 8'hA5;
      3'd1:    cur_byte = frame_q[31:24];
      3'd2:    cur_byte = frame_q[23:16];
      3'd3:    cur_byte = frame_q[15:8];
      3'd4:    cur_byte = frame_q[7:0];
      default: cur_byte = frame_q[39:32];
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {seq_q, trace_instr};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      frame_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      frame_q    <= frame_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      seq_d    = seq_q + 8'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    frame_d    = frame_q;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (pop) begin
          frame_d    = mem[rd_ptr_q];
          byte_idx_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          if (byte_idx_q < 3'd5) begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_idx_q];
      default: tx = 1'b1;
    endcase
    busy       = (state_q != IDLE);
    fifo_level = count_q;
    overflow   = overflow_q;
    drop_count = drop_cnt_q;
  end

endmodule

// File: tb/tb_mips_trace_uart_tx.sv
// Directed bench for mips_trace_uart_tx: decodes the UART line mid-bit and compares
// every frame, FIFO level and overflow counter against hand-computed values.
module tb_mips_trace_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trace_valid = 1'b0;
  logic [31:0] trace_instr = 32'h0;
  logic        enable = 1'b1;
  logic        clear_overflow = 1'b0;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_count;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          busyCycles = 0;
  logic [7:0]  rxSeq = 8'h0;
  bit          timedOut = 1'b0;
  bit          txStayedHigh;

  mips_trace_uart_tx #(
    .CLKS_PER_BIT(4),
    .DEPTH(4),
    .FILTER_NOP(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trace_valid(trace_valid),
    .trace_instr(trace_instr),
    .enable(enable),
    .clear_overflow(clear_overflow),
    .tx(tx),
    .busy(busy),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] wordFor(input int i);
    return 32'h2408_0100 + 32'(i);
  endfunction

  task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    if (busy) busyCycles++;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic clr);
    trace_valid    = valid;
    trace_instr    = instr;
    clear_overflow = clr;
    stepCycle();
    trace_valid    = 1'b0;
    trace_instr    = 32'h0;
    clear_overflow = 1'b0;
  endtask

  task automatic resetDut();
    trace_valid    = 1'b0;
    trace_instr    = 32'h0;
    clear_overflow = 1'b0;
    enable         = 1'b1;
    rst            = 1'b1;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    stepCycle();
  endtask

  // Returns at the first negedge on which the start bit is visible.
  task automatic waitFall(input string tag);
    int n;
    n = 0;
    timedOut = 1'b0;
    do begin
      stepCycle();
      n++;
    end while (tx !== 1'b0 && n < 400);
    if (tx !== 1'b0) begin
      checkOutput({tag, "_start_timeout"}, 40'(tx), 40'(0));
      timedOut = 1'b1;
    end
  endtask

  task automatic receiveFrame(input string tag, input logic [31:0] instr, input logic [7:0] seq, input bit doCheck);
    logic [7:0] expBytes [6];
    logic [9:0] got;
    expBytes = '{8'hA5, instr[31:24], instr[23:16], instr[15:8], instr[7:0], seq};
    for (int b = 0; b < 6; b++) begin
      waitFall(tag);
      if (timedOut) return;
      stepCycle();
      stepCycle();
      got[0] = tx;
      for (int k = 1; k < 10; k++) begin
        repeat (4) stepCycle();
        got[k] = tx;
      end
      if (b == 5) rxSeq = got[8:1];
      if (doCheck) begin
        checkOutput($sformatf("%s_byte%0d", tag, b), 40'(got), 40'({1'b1, expBytes[b], 1'b0}));
      end
    end
  endtask

  initial begin
    // T1: reset values and a single frame
    resetDut();
    checkOutput("rst_tx", 40'(tx), 40'(1));
    checkOutput("rst_busy", 40'(busy), 40'(0));
    checkOutput("rst_level", 40'(fifo_level), 40'(0));
    checkOutput("rst_overflow", 40'(overflow), 40'(0));
    checkOutput("rst_drop_count", 40'(drop_count), 40'(0));
    busyCycles = 0;
    applyStimulus(1'b1, 32'h2009000A, 1'b0);
    receiveFrame("t1", 32'h2009000A, 8'h00, 1'b1);
    repeat (3) stepCycle();
    checkOutput("t1_busy_cycles", 40'(busyCycles), 40'(240));
    checkOutput("t1_idle_tx", 40'(tx), 40'(1));
    checkOutput("t1_idle_busy", 40'(busy), 40'(0));

    // T2: NOP words are never captured
    resetDut();
    txStayedHigh = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h0, 1'b0);
      if (tx !== 1'b1) txStayedHigh = 1'b0;
    end
    checkOutput("t2_level", 40'(fifo_level), 40'(0));
    checkOutput("t2_tx_high", 40'(txStayedHigh), 40'(1));
    applyStimulus(1'b1, 32'h8C080004, 1'b0);
    receiveFrame("t2", 32'h8C080004, 8'h00, 1'b1);

    // T3: six back-to-back pushes, the sixth is dropped
    resetDut();
    fork
      begin
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, wordFor(i), 1'b0);
        checkOutput("t3_level", 40'(fifo_level), 40'(4));
        checkOutput("t3_drop_count", 40'(drop_count), 40'(1));
        checkOutput("t3_overflow", 40'(overflow), 40'(1));
      end
      begin
        for (int f = 0; f < 5; f++) begin
          receiveFrame($sformatf("t3_f%0d", f), wordFor(f), 8'(f), 1'b1);
        end
      end
    join
    repeat (3) stepCycle();
    checkOutput("t3_drained_level", 40'(fifo_level), 40'(0));

    // T4: drop and clear in the same cycle, then clear alone
    resetDut();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, wordFor(i), 1'b0);
    applyStimulus(1'b1, wordFor(5), 1'b1);
    checkOutput("t4_set_wins", 40'(overflow), 40'(1));
    checkOutput("t4_drop_count", 40'(drop_count), 40'(1));
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t4_cleared", 40'(overflow), 40'(0));
    checkOutput("t4_drop_kept", 40'(drop_count), 40'(1));

    // T5: asynchronous reset during DATA of byte 2 with three entries queued
    resetDut();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, wordFor(i), 1'b0);
    repeat (90) stepCycle();
    checkOutput("t5_busy_before", 40'(busy), 40'(1));
    checkOutput("t5_level_before", 40'(fifo_level), 40'(3));
    #1 rst = 1'b1;
    #1;
    checkOutput("t5_async_tx", 40'(tx), 40'(1));
    checkOutput("t5_async_busy", 40'(busy), 40'(0));
    checkOutput("t5_async_level", 40'(fifo_level), 40'(0));
    stepCycle();
    rst = 1'b0;
    stepCycle();
    applyStimulus(1'b1, 32'h3C01ABCD, 1'b0);
    receiveFrame("t5", 32'h3C01ABCD, 8'h00, 1'b1);

    // T6: sequence number wraps after 256 frames
    resetDut();
    for (int k = 0; k < 257; k++) begin
      applyStimulus(1'b1, 32'h1000_0000 + 32'(k), 1'b0);
      receiveFrame($sformatf("t6_f%0d", k), 32'h1000_0000 + 32'(k), 8'(k), k >= 255);
      if (timedOut) break;
      if (k == 255) checkOutput("t6_seq_ff", 40'(rxSeq), 40'(8'hFF));
      if (k == 256) checkOutput("t6_seq_wrap", 40'(rxSeq), 40'(8'h00));
    end
    checkOutput("t6_no_drops", 40'(drop_count), 40'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
